// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DW_BYTES = 8;
  localparam int unsigned DW_BITS  = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    ERR   = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Natural-alignment check of a byte offset within a doubleword.
  function automatic logic misaligned(input size_e sz, input logic [2:0] off);
    logic r;
    case (sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract/extend and store read-modify-write merge.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]         i_offset,
  input  size_e              i_size,
  input  logic               i_unsigned,
  input  logic [DW_BITS-1:0] i_rdata,
  input  logic [DW_BITS-1:0] i_wdata,
  output logic [DW_BITS-1:0] o_load_c,
  output logic [DW_BITS-1:0] o_merge_c
);

  logic [5:0]           w_shamt;
  logic [DW_BITS-1:0]   w_rshift;
  logic [DW_BITS-1:0]   w_wshift;
  logic [DW_BYTES-1:0]  w_size_mask;
  logic [DW_BYTES-1:0]  w_byte_mask;
  logic                 w_sext;

  assign w_shamt     = {i_offset, 3'b000};
  assign w_rshift    = i_rdata >> w_shamt;
  assign w_wshift    = i_wdata << w_shamt;
  assign w_byte_mask = w_size_mask << i_offset;

  // Load extraction with sign or zero extension from the top bit of the size.
  always_comb begin
    o_load_c    = w_rshift;
    w_size_mask = 8'hFF;
    w_sext      = 1'b0;
    case (i_size)
      SZ_B: begin
        w_size_mask = 8'h01;
        w_sext      = ~i_unsigned & w_rshift[7];
        o_load_c    = {{56{w_sext}}, w_rshift[7:0]};
      end
      SZ_H: begin
        w_size_mask = 8'h03;
        w_sext      = ~i_unsigned & w_rshift[15];
        o_load_c    = {{48{w_sext}}, w_rshift[15:0]};
      end
      SZ_W: begin
        w_size_mask = 8'h0F;
        w_sext      = ~i_unsigned & w_rshift[31];
        o_load_c    = {{32{w_sext}}, w_rshift[31:0]};
      end
      default: begin
        w_size_mask = 8'hFF;
        o_load_c    = w_rshift;
      end
    endcase
  end

  // Replace the addressed bytes with right-aligned store data, keep the rest.
  always_comb begin
    o_merge_c = i_rdata;
    for (int i = 0; i < int'(DW_BYTES); i++) begin
      if (w_byte_mask[i]) o_merge_c[8*i +: 8] = w_wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for a synchronous 64-bit doubleword data memory.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [63:0]       REQ_ADDR,
  input  logic [63:0]       REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [63:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WR,
  output logic [63:0]       MEM_WDATA,
  input  logic [63:0]       MEM_RDATA
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

  logic                r_req_ready, w_req_ready_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [63:0]         r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_mem_wr, w_mem_wr_nxt;
  logic [63:0]         r_mem_wdata, w_mem_wdata_nxt;

  logic                r_write;
  size_e               r_size;
  logic                r_unsigned;
  logic [ADDR_W-1:0]   r_addr;
  logic [63:0]         r_wdata;

  size_e               w_req_size;
  logic                w_accept;
  logic                w_bad;
  logic [ADDR_W-1:0]   w_dw_addr;
  logic [63:0]         w_load;
  logic [63:0]         w_merge;

  assign w_req_size = size_e'(REQ_SIZE);
  assign w_bad      = misaligned(w_req_size, REQ_ADDR[2:0]) | (|REQ_ADDR[63:ADDR_W]);
  assign w_dw_addr  = {REQ_ADDR[ADDR_W-1:3], 3'b000};

  assign REQ_READY = r_req_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WR    = r_mem_wr;
  assign MEM_WDATA = r_mem_wdata;

  // Lane steering works on the latched request against live memory data.
  dmem_lane_align u_align (
    .i_offset   (r_addr[2:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_rdata    (MEM_RDATA),
    .i_wdata    (r_wdata),
    .o_load_c   (w_load),
    .o_merge_c  (w_merge)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wr_nxt    = 1'b0;
    w_mem_wdata_nxt = r_mem_wdata;
    w_accept        = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (REQ_VALID && r_req_ready) begin
          w_accept        = 1'b1;
          w_req_ready_nxt = 1'b0;
          if (w_bad) begin
            w_state_nxt = ERR;
          end else if (!REQ_WRITE || (w_req_size != SZ_D)) begin
            w_state_nxt    = READ;
            w_cnt_nxt      = CNT_W'(MEM_LAT - 1);
            w_mem_addr_nxt = w_dw_addr;
          end else begin
            w_state_nxt     = WRITE;
            w_mem_addr_nxt  = w_dw_addr;
            w_mem_wr_nxt    = 1'b1;
            w_mem_wdata_nxt = REQ_WDATA;
          end
        end
      end
      READ: begin
        if (r_cnt == '0) begin
          if (r_write) begin
            w_state_nxt     = WRITE;
            w_mem_wr_nxt    = 1'b1;
            w_mem_wdata_nxt = w_merge;
          end else begin
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = w_load;
            w_rsp_err_nxt   = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WRITE: begin
        w_state_nxt     = RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b0;
      end
      ERR: begin
        w_state_nxt     = RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b1;
      end
      RESP: begin
        if (RSP_READY) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_req_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any operation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  // Request fields captured at acceptance so the core may move on.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_write    <= 1'b0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_write    <= REQ_WRITE;
      r_size     <= w_req_size;
      r_unsigned <= REQ_UNSIGNED;
      r_addr     <= REQ_ADDR[ADDR_W-1:0];
      r_wdata    <= REQ_WDATA;
    end
  end

endmodule
